// File: rtl/vertex_pkg.sv
// Shared definitions for the vertex collector: component geometry and lane
// names used when packing adder-tree results into vertices.
package vertex_pkg;

    localparam int COMP_W = 32;
    localparam int LANES  = 4;
    localparam int VTX_W  = COMP_W * LANES;

    typedef logic [COMP_W-1:0] comp_t;
    typedef logic [VTX_W-1:0]  vtx_t;

    // Lane index of each vertex component inside vtx_t
    localparam logic [1:0] X = 2'd0;
    localparam logic [1:0] Y = 2'd1;
    localparam logic [1:0] Z = 2'd2;
    localparam logic [1:0] W = 2'd3;

endpackage : vertex_pkg

// File: rtl/vertex_collector_sync_fifo.sv
// sync_fifo: generic single-clock FIFO with synchronous active-low reset.
// Push and pop may occur in the same cycle in any state, including full.
// The head word (rdata_o) is read straight from storage, so it stays stable
// until popped. Storage is cleared on reset so the head reads as zero.
module sync_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q,  level_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Qualify requests and compute next pointer / occupancy values
    always_comb begin
        pop_ok_s  = pop_i && !empty_o;
        push_ok_s = push_i && (!full_o || pop_ok_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer, occupancy and storage registers
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
        end
    end

endmodule : sync_fifo

// File: rtl/vertex_collector.sv
// vertex_collector: packs groups of four adder-tree results into 128-bit
// vertices (lane 0 = x ... lane 3 = w), buffers them in a small FIFO and
// hands them downstream over valid/ready. A flush emits a partial vertex
// with unfilled lanes zero; if the FIFO has no room the flush is held
// pending and input is stalled until it can be pushed.
// Optional build macro: VTX_STATS_EN adds the vtx_count push counter output.
module vertex_collector #(
    parameter int COMP_W     = vertex_pkg::COMP_W,
    parameter int LANES      = vertex_pkg::LANES,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          res_valid,
    output logic                          res_ready,
    input  logic [COMP_W-1:0]             res_data,
    input  logic                          flush,
    output logic                          vtx_valid,
    input  logic                          vtx_ready,
    output logic [LANES*COMP_W-1:0]       vtx_data,
    output logic [1:0]                    comp_idx,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef VTX_STATS_EN
    ,
    output logic [15:0]                   vtx_count
`endif
);

    import vertex_pkg::*;

    localparam int VW = LANES * COMP_W;

    logic [1:0]    comp_idx_q, comp_idx_d;
    logic [VW-1:0] stage_q,    stage_d;
    logic          pend_q,     pend_d;

    logic [VW-1:0] merged_s;
    logic [VW-1:0] push_data_s;
    logic          push_s;
    logic          pop_s;
    logic          space_s;
    logic          accept_s;
    logic          complete_s;
    logic          full_s;
    logic          empty_s;

    assign vtx_valid = !empty_s;
    assign comp_idx  = comp_idx_q;

    // Handshake qualification: room exists when not full or the head leaves now
    always_comb begin
        pop_s      = vtx_valid && vtx_ready;
        space_s    = !full_s || pop_s;
        res_ready  = enable && !pend_q && ((comp_idx_q != W) || space_s);
        accept_s   = res_valid && res_ready;
        complete_s = accept_s && (comp_idx_q == W);
    end

    // Staging contents with the incoming word dropped into its lane
    always_comb begin
        merged_s = stage_q;
        if (accept_s) begin
            merged_s[int'(comp_idx_q)*COMP_W +: COMP_W] = res_data;
        end else begin
            merged_s = stage_q;
        end
    end

    // Next-state for lane index, staging and pending flush; decides FIFO push
    always_comb begin
        comp_idx_d  = comp_idx_q;
        stage_d     = stage_q;
        pend_d      = pend_q;
        push_s      = 1'b0;
        push_data_s = merged_s;
        if (pend_q) begin
            // No accepts happen while pending, so merged_s equals stage_q
            if (space_s) begin
                push_s     = 1'b1;
                stage_d    = '0;
                comp_idx_d = X;
                pend_d     = 1'b0;
            end else begin
                pend_d     = 1'b1;
            end
        end else begin
            if (accept_s) begin
                comp_idx_d = comp_idx_q + 2'd1;
                if (complete_s) begin
                    push_s  = 1'b1;
                    stage_d = '0;
                end else begin
                    stage_d = merged_s;
                end
            end else begin
                comp_idx_d = comp_idx_q;
            end
            // Flush only matters if a partial vertex remains after the accept
            if (flush && !complete_s && (accept_s || (comp_idx_q != X))) begin
                if (space_s) begin
                    push_s     = 1'b1;
                    stage_d    = '0;
                    comp_idx_d = X;
                end else begin
                    pend_d     = 1'b1;
                end
            end else begin
                pend_d = 1'b0;
            end
        end
    end

    // Collector state registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            comp_idx_q <= X;
            stage_q    <= '0;
            pend_q     <= 1'b0;
        end else begin
            comp_idx_q <= comp_idx_d;
            stage_q    <= stage_d;
            pend_q     <= pend_d;
        end
    end

    sync_fifo #(
        .WIDTH (VW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_n_i (reset),
        .push_i  (push_s),
        .wdata_i (push_data_s),
        .pop_i   (pop_s),
        .rdata_o (vtx_data),
        .full_o  (full_s),
        .empty_o (empty_s),
        .level_o (fifo_level)
    );

`ifdef VTX_STATS_EN
    logic [15:0] vtx_count_q;

    // Count every vertex pushed into the FIFO, wrapping at 16 bits
    always_ff @(posedge clk) begin
        if (!reset) begin
            vtx_count_q <= 16'd0;
        end else if (push_s) begin
            vtx_count_q <= vtx_count_q + 16'd1;
        end else begin
            vtx_count_q <= vtx_count_q;
        end
    end

    assign vtx_count = vtx_count_q;
`endif

endmodule : vertex_collector

// File: tb/tb_vertex_collector.sv
// Scoreboard bench for vertex_collector. The reference model keeps the
// partial vertex as a queue of words and the FIFO as a count of queued
// vertices; expected vertices go into exp_q and a separate monitor checks
// each one the DUT hands over.
module tb_vertex_collector;

    logic         clk = 1'b0;
    logic         reset, enable, res_valid, res_ready, flush;
    logic [31:0]  res_data;
    logic         vtx_valid, vtx_ready;
    logic [127:0] vtx_data;
    logic [1:0]   comp_idx;
    logic [2:0]   fifo_level;
`ifdef VTX_STATS_EN
    logic [15:0]  vtx_count;
`endif

    vertex_collector dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .flush      (flush),
        .vtx_valid  (vtx_valid),
        .vtx_ready  (vtx_ready),
        .vtx_data   (vtx_data),
        .comp_idx   (comp_idx),
        .fifo_level (fifo_level)
`ifdef VTX_STATS_EN
        ,
        .vtx_count  (vtx_count)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [31:0]  mpart[$];
    logic [127:0] exp_q[$];
    int           mlevel = 0;
    bit           mpend  = 0;
    int           mcount = 0;
    bit           chk_zero = 0;
    bit           last_acc = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Move the model's partial vertex (zero padded) into the expected queue
    task automatic push_vtx();
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < mpart.size(); i++) v[i*32 +: 32] = mpart[i];
        exp_q.push_back(v);
        mpart.delete();
        mcount = (mcount + 1) % 65536;
    endtask

    // One clock: drive inputs, check visible state against the model, advance the model
    task automatic step(input bit rst, input bit en, input bit rv, input logic [31:0] d,
                        input bit fl, input bit vr);
        bit pop, space, rr, acc, done;
        int pushes;
        @(negedge clk);
        reset = rst; enable = en; res_valid = rv; res_data = d; flush = fl; vtx_ready = vr;
        #2;
        last_acc = 0;
        if (!rst) begin
            mpart.delete(); exp_q.delete();
            mlevel = 0; mpend = 0; mcount = 0; chk_zero = 1;
        end else begin
            chk("vtx_valid", vtx_valid, mlevel != 0);
            chk("fifo_level", fifo_level, mlevel);
            chk("comp_idx", comp_idx, mpart.size());
`ifdef VTX_STATS_EN
            chk("vtx_count", vtx_count, mcount);
`endif
            if (chk_zero) chk("vtx_data_after_reset", vtx_data, 128'd0);
            chk_zero = 0;
            pop   = (mlevel != 0) && vr;
            space = (mlevel < 4) || pop;
            rr    = en && !mpend && (mpart.size() != 3 || space);
            chk("res_ready", res_ready, rr);
            acc = rv && rr;
            last_acc = acc;
            pushes = exp_q.size();
            if (mpend) begin
                if (space) begin push_vtx(); mpend = 0; end
            end else begin
                done = 0;
                if (acc) begin
                    mpart.push_back(d);
                    if (mpart.size() == 4) begin push_vtx(); done = 1; end
                end
                if (fl && !done && mpart.size() != 0) begin
                    if (space) push_vtx();
                    else mpend = 1;
                end
            end
            pushes = exp_q.size() - pushes;
            mlevel = mlevel + pushes - (pop ? 1 : 0);
        end
    endtask

    task automatic feed(input logic [31:0] w, input bit vr);
        int k = 0;
        do begin
            step(1, 1, 1, w, 0, vr);
            k++;
        end while (!last_acc && k < 20);
        chk("feed_accept", last_acc, 1'b1);
    endtask

    task automatic idle(input int n, input bit vr);
        for (int i = 0; i < n; i++) step(1, 1, 0, 32'd0, 0, vr);
    endtask

    // Monitor: compare every vertex the DUT hands over with the scoreboard head
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (reset && vtx_valid && vtx_ready) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_vertex: got %0h expected none", vtx_data);
                end else begin
                    chk("vtx_data", vtx_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int n;
        reset = 0; enable = 0; res_valid = 0; res_data = 0; flush = 0; vtx_ready = 0;
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Fill and drain
        for (int i = 1; i <= 4; i++) feed(i, 1);
        idle(3, 1);

        // Backpressure: 20 words with downstream stalled
        n = 0;
        for (int c = 0; c < 30; c++) begin
            step(1, 1, n < 20, n, 0, 0);
            if (last_acc) n++;
        end
        chk("accepted_before_stall", n, 19);
        for (int c = 0; c < 40 && n < 20; c++) begin
            step(1, 1, 1, n, 0, 1);
            if (last_acc) n++;
        end
        idle(8, 1);

        // Simultaneous push and pop at full
        for (int i = 0; i < 19; i++) feed(32'h100 + i, 0);
        step(1, 1, 1, 32'h1FF, 0, 1);
        chk("push_pop_full_accept", last_acc, 1'b1);
        idle(8, 1);

        // Flush of a partial vertex, then flush with nothing staged
        feed(10, 1); feed(11, 1);
        step(1, 1, 0, 0, 1, 1);
        idle(3, 1);
        step(1, 1, 0, 0, 1, 1);
        idle(3, 1);

        // Pending flush with the FIFO full
        for (int i = 0; i < 16; i++) feed(32'h200 + i, 0);
        feed(7, 0);
        step(1, 1, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 32'h55, 1, 0);
        step(1, 1, 1, 32'h56, 0, 1);
        idle(8, 1);

        // Reset mid-operation
        for (int i = 0; i < 10; i++) feed(32'h300 + i, 0);
        step(0, 1, 1, 32'h77, 0, 1);
        for (int i = 0; i < 4; i++) feed(32'h400 + i, 1);
        idle(4, 1);

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            step($urandom_range(0, 99) != 0, $urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
                 $urandom, $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0);
        end
        idle(12, 1);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_vertex_collector
